// File: rtl/risc_vt_pkg.sv
// Shared constants and types for the risc_vt instruction-fetch slice.
package risc_vt_pkg;

   localparam int          INST_BYTES     = 4;
   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
   localparam int          DEF_ADDR_WIDTH = 32;
   localparam int          DEF_DATA_WIDTH = 32;

   typedef struct packed {
      logic [DEF_ADDR_WIDTH-1:0] pc;
      logic [DEF_DATA_WIDTH-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/risc_vt_sync_fifo.sv
// Synchronous shift-style FIFO: entry 0 is always the head, so the head output
// comes straight from a flop with no read mux.
module risc_vt_sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_pop;
   logic             do_push;
   logic [AW-1:0]    wr_idx;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign dout    = mem[0];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   // count==DEPTH with a pop truncates to 0 and wraps to DEPTH-1
   assign wr_idx  = AW'(count) - AW'(do_pop);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_pop) begin
            for (int i = 0; i < DEPTH-1; i++) mem[i] <= mem[i+1];
            mem[DEPTH-1] <= '0;
         end
         if (do_push) mem[wr_idx] <= din;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/risc_vt_fetch.sv
// Instruction-fetch unit: owns the fetch PC, issues pipelined program-memory
// reads under a FIFO credit limit, and handles redirects by dropping late data.
module risc_vt_fetch
   import risc_vt_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    FIFO_DEPTH = 4,
   parameter int                    MAX_OUTST  = 2,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [DATA_WIDTH-1:0] inst_data,
   output logic [ADDR_WIDTH-1:0] inst_pc,
   output logic                  prog_rd,
   output logic [ADDR_WIDTH-1:0] prog_addr,
   input  logic                  prog_rd_en,
   input  logic                  prog_dout_rdy,
   input  logic [DATA_WIDTH-1:0] prog_din
);

   localparam int                    OW   = $clog2(MAX_OUTST+1);
   localparam int                    CW   = $clog2(FIFO_DEPTH+1);
   localparam int                    EW   = ADDR_WIDTH + DATA_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INST_BYTES);

   logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_next, resp_pc, target;
   logic [OW-1:0]         outst, outst_next, drop;
   logic [CW-1:0]         fifo_count, fifo_count_next;
   logic                  accept, push, pop, issue;
   logic                  fifo_full, fifo_empty;
   logic [EW-1:0]         fifo_head;

   assign accept = prog_rd && prog_rd_en;
   assign target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
   assign push   = prog_dout_rdy && (drop == '0) && !redirect;
   assign pop    = inst_valid && inst_ready && !redirect;

   always_comb begin
      outst_next      = outst + OW'(accept) - OW'(prog_dout_rdy);
      fetch_pc_next   = fetch_pc;
      fifo_count_next = fifo_count + CW'(push) - CW'(pop);
      if (redirect) begin
         fetch_pc_next   = target;
         fifo_count_next = '0;
      end else if (accept) begin
         fetch_pc_next   = fetch_pc + STEP;
      end
      // every outstanding read already owns a FIFO slot, so pushes never overflow
      issue = !redirect && (int'(outst_next) < MAX_OUTST)
              && (int'(fifo_count_next) + int'(outst_next) < FIFO_DEPTH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc  <= RESET_PC;
         resp_pc   <= RESET_PC;
         outst     <= '0;
         drop      <= '0;
         prog_rd   <= 1'b0;
         prog_addr <= '0;
      end else begin
         fetch_pc <= fetch_pc_next;
         outst    <= outst_next;
         prog_rd  <= issue;
         if (issue) prog_addr <= fetch_pc_next;
         if (redirect) begin
            // every read still in flight after this edge belongs to the old stream
            resp_pc <= target;
            drop    <= outst_next;
         end else begin
            if (push) resp_pc <= resp_pc + STEP;
            if (prog_dout_rdy && (drop != '0)) drop <= drop - OW'(1);
         end
      end
   end

   risc_vt_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (redirect),
      .push  (push),
      .din   ({resp_pc, prog_din}),
      .pop   (pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign inst_valid          = !fifo_empty;
   assign {inst_pc, inst_data} = fifo_head;

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_risc_vt_fetch.sv
// Bench for risc_vt_fetch: in-order memory model with selectable latency and a
// scoreboard of expected {pc, inst} entries fed from modelled memory responses.
module tb_risc_vt_fetch;
   import risc_vt_pkg::*;

   localparam int MAXO = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        prog_rd;
   logic [31:0] prog_addr;
   logic        prog_rd_en;
   logic        prog_dout_rdy;
   logic [31:0] prog_din;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int mem_lat = 1;
   int acc_cnt = 0;
   int pop_cnt = 0;
   int tb_drop = 0;
   logic [31:0] exp_req_pc = 32'h0;
   logic [31:0] exp_resp_pc = 32'h0;
   logic [31:0] last_pc = 32'h0;
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   fetch_entry_t exp_q[$];
   fetch_entry_t exp_e;
   fetch_entry_t got_e;

   risc_vt_fetch dut (
      .clk           (clk),
      .rst           (rst),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst_data     (inst_data),
      .inst_pc       (inst_pc),
      .prog_rd       (prog_rd),
      .prog_addr     (prog_addr),
      .prog_rd_en    (prog_rd_en),
      .prog_dout_rdy (prog_dout_rdy),
      .prog_din      (prog_din)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
   endfunction

   // memory responds in order, one word per cycle, mem_lat cycles after accept
   always @(posedge clk) begin
      cyc++;
      #1;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
         prog_dout_rdy = 1'b1;
         prog_din      = mem_word(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else begin
         prog_dout_rdy = 1'b0;
         prog_din      = $urandom;
      end
   end

   // monitor + scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         pend_addr.delete();
         pend_due.delete();
         exp_q.delete();
         tb_drop     = 0;
         exp_req_pc  = DEF_RESET_PC;
         exp_resp_pc = DEF_RESET_PC;
      end else begin
         if (inst_valid && inst_ready && !redirect) begin
            checks++;
            got_e.pc   = inst_pc;
            got_e.inst = inst_data;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL deliver: got pc=%h inst=%h, expected no instruction", inst_pc, inst_data);
            end else begin
               exp_e = exp_q.pop_front();
               if (got_e !== exp_e) begin
                  errors++;
                  $display("FAIL deliver: got pc=%h inst=%h, expected pc=%h inst=%h",
                           inst_pc, inst_data, exp_e.pc, exp_e.inst);
               end
            end
            last_pc = inst_pc;
            pop_cnt++;
         end
         if (prog_dout_rdy && !redirect) begin
            if (tb_drop > 0) tb_drop--;
            else begin
               exp_e.pc   = exp_resp_pc;
               exp_e.inst = mem_word(exp_resp_pc);
               exp_q.push_back(exp_e);
               exp_resp_pc += 32'd4;
            end
         end
         if (prog_rd && prog_rd_en) begin
            checks++;
            if (prog_addr !== exp_req_pc) begin
               errors++;
               $display("FAIL req_addr: got %h, expected %h", prog_addr, exp_req_pc);
            end
            exp_req_pc += 32'd4;
            pend_addr.push_back(prog_addr);
            pend_due.push_back(cyc + mem_lat);
            acc_cnt++;
            checks++;
            if (pend_addr.size() > MAXO) begin
               errors++;
               $display("FAIL outst_bound: got %0d outstanding, expected at most %0d", pend_addr.size(), MAXO);
            end
         end
         if (redirect) begin
            exp_q.delete();
            tb_drop     = pend_addr.size();
            exp_req_pc  = {redirect_pc[31:2], 2'b00};
            exp_resp_pc = {redirect_pc[31:2], 2'b00};
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_reset(input int lat);
      rst = 1'b1; redirect = 1'b0; inst_ready = 1'b0; prog_rd_en = 1'b0; mem_lat = lat;
      tick(); tick();
      acc_cnt = 0; pop_cnt = 0;
      rst = 1'b0;
   endtask

   task automatic wait_handshake(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (inst_valid && inst_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic pulse_redirect(input logic [31:0] pc);
      redirect = 1'b1; redirect_pc = pc;
      tick();
      redirect = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0; prog_rd_en = 1'b0;
      tick(); tick();
      checks++;
      if ({prog_rd, prog_addr, inst_valid, inst_data, inst_pc} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got rd=%b addr=%h v=%b data=%h pc=%h, expected all 0",
                  prog_rd, prog_addr, inst_valid, inst_data, inst_pc);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (prog_rd !== 1'b1 || prog_addr !== 32'h0) begin
         errors++;
         $display("FAIL first_req: got rd=%b addr=%h, expected rd=1 addr=00000000", prog_rd, prog_addr);
      end
   endtask

   task automatic test_stream();
      apply_reset(1);
      prog_rd_en = 1'b1; inst_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (prog_rd !== 1'b1) begin
            errors++;
            $display("FAIL stream_rd: cycle %0d got prog_rd=%b, expected 1", i, prog_rd);
         end
      end
      checks++;
      if (pop_cnt < 6) begin
         errors++;
         $display("FAIL stream_count: got %0d delivered, expected at least 6", pop_cnt);
      end
   endtask

   task automatic test_backpressure();
      bit found;
      apply_reset(1);
      prog_rd_en = 1'b1;
      repeat (20) tick();
      checks++;
      if (acc_cnt != 4 || prog_rd !== 1'b0) begin
         errors++;
         $display("FAIL bp_credit: got %0d accepts rd=%b, expected 4 accepts rd=0", acc_cnt, prog_rd);
      end
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== mem_word(32'h0)) begin
         errors++;
         $display("FAIL bp_head: got v=%b pc=%h data=%h, expected v=1 pc=00000000 data=%h",
                  inst_valid, inst_pc, inst_data, mem_word(32'h0));
      end
      inst_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (prog_rd) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found || prog_addr !== 32'h10) begin
         errors++;
         $display("FAIL bp_resume: got found=%b addr=%h, expected found=1 addr=00000010", found, prog_addr);
      end
      repeat (10) tick();
   endtask

   task automatic test_stall();
      apply_reset(1);
      inst_ready = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (prog_rd !== 1'b1 || prog_addr !== 32'h0 || acc_cnt != 0) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d got rd=%b addr=%h acc=%0d, expected rd=1 addr=00000000 acc=0",
                     i, prog_rd, prog_addr, acc_cnt);
         end
         tick();
      end
      prog_rd_en = 1'b1;
      repeat (10) tick();
      checks++;
      if (pop_cnt < 4) begin
         errors++;
         $display("FAIL stall_resume: got %0d delivered, expected at least 4", pop_cnt);
      end
   endtask

   task automatic test_redirect_outst();
      bit ok;
      apply_reset(3);
      prog_rd_en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (pend_addr.size() == 2 && inst_valid) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL redir_setup: got no cycle with 2 outstanding and valid head, expected one");
      end
      pulse_redirect(32'h0000_0202);
      checks++;
      if (inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_flush: got inst_valid=%b, expected 0", inst_valid);
      end
      inst_ready = 1'b1;
      wait_handshake(30, ok);
      checks++;
      if (!ok || inst_pc !== 32'h200) begin
         errors++;
         $display("FAIL redir_target: got ok=%b pc=%h, expected ok=1 pc=00000200", ok, inst_pc);
      end
      repeat (8) tick();
   endtask

   task automatic test_redirect_collide();
      bit ok;
      apply_reset(1);
      prog_rd_en = 1'b1; inst_ready = 1'b1;
      repeat (6) tick();
      checks++;
      if (!(prog_rd && prog_dout_rdy && inst_valid)) begin
         errors++;
         $display("FAIL collide_setup: got rd=%b rdy=%b v=%b, expected all 1", prog_rd, prog_dout_rdy, inst_valid);
      end
      pulse_redirect(32'h0000_0100);
      wait_handshake(20, ok);
      checks++;
      if (!ok || inst_pc !== 32'h100) begin
         errors++;
         $display("FAIL collide_target: got ok=%b pc=%h, expected ok=1 pc=00000100", ok, inst_pc);
      end
      repeat (3) tick();
      redirect = 1'b1; redirect_pc = 32'h0000_0300;
      tick();
      redirect_pc = 32'h0000_0400;
      tick();
      redirect = 1'b0;
      wait_handshake(20, ok);
      checks++;
      if (!ok || inst_pc !== 32'h400) begin
         errors++;
         $display("FAIL double_redir: got ok=%b pc=%h, expected ok=1 pc=00000400", ok, inst_pc);
      end
      repeat (4) tick();
      pulse_redirect(32'hFFFF_FFF8);
      repeat (15) tick();
      checks++;
      if (last_pc >= 32'h40) begin
         errors++;
         $display("FAIL wrap: got last pc=%h, expected below 00000040 after wrap", last_pc);
      end
   endtask

   task automatic test_reset_midstream();
      bit ok;
      apply_reset(3);
      prog_rd_en = 1'b1; inst_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (pend_addr.size() == 2 && pop_cnt > 0) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rst_mid_setup: got no cycle with 2 outstanding, expected one");
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({prog_rd, prog_addr, inst_valid, inst_data, inst_pc} !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs: got rd=%b addr=%h v=%b data=%h pc=%h, expected all 0",
                  prog_rd, prog_addr, inst_valid, inst_data, inst_pc);
      end
      rst = 1'b0;
      wait_handshake(20, ok);
      checks++;
      if (!ok || inst_pc !== DEF_RESET_PC || inst_data !== mem_word(DEF_RESET_PC)) begin
         errors++;
         $display("FAIL rst_mid_restart: got ok=%b pc=%h data=%h, expected ok=1 pc=%h data=%h",
                  ok, inst_pc, inst_data, DEF_RESET_PC, mem_word(DEF_RESET_PC));
      end
      repeat (6) tick();
   endtask

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0; prog_rd_en = 1'b0;
      prog_dout_rdy = 1'b0; prog_din = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_stall();
      test_redirect_outst();
      test_redirect_collide();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
